// File: rtl/vmode_lock_ctrl.sv
// NTSC/PAL acquisition and lock controller driven by VSYNC falling-edge periods.
// Optional macro SAVOMAX_CSYNC_GATE_EN: registered csync gate that idles high while unlocked.
module vmode_lock_ctrl #(
    parameter int unsigned CLK_FREQ         = 250_000,
    parameter int unsigned PAL_THRESHOLD_MS = 18,
    parameter int unsigned MIN_PERIOD_MS    = 12,
    parameter int unsigned MAX_PERIOD_MS    = 25,
    parameter int unsigned TIMEOUT_MS       = 50,
    parameter int unsigned CONFIRM_COUNT    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        vsync_in,
    input  logic        csync_in,
    output logic        csync_out,
    output logic [2:0]  format_out,
    output logic        locked_out,
    output logic [31:0] period_out,
    output logic        lost_out
);
    localparam logic [31:0] CYC_PER_MS  = 32'(CLK_FREQ / 1000);
    localparam logic [31:0] THR_CYC     = CYC_PER_MS * 32'(PAL_THRESHOLD_MS);
    localparam logic [31:0] MIN_CYC     = CYC_PER_MS * 32'(MIN_PERIOD_MS);
    localparam logic [31:0] MAX_CYC     = CYC_PER_MS * 32'(MAX_PERIOD_MS);
    localparam logic [31:0] TIMEOUT_CYC = CYC_PER_MS * 32'(TIMEOUT_MS);
    localparam logic [3:0]  CONFIRM     = 4'(CONFIRM_COUNT);

    localparam logic [2:0] FMT_NONE = 3'b000;
    localparam logic [2:0] FMT_NTSC = 3'b010;
    localparam logic [2:0] FMT_PAL  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  agree_q, agree_d, miss_q, miss_d;
    logic [2:0]  cand_q, cand_d, format_q, format_d;
    logic        locked_q, locked_d, lost_q, lost_d;
    logic [31:0] period_q, period_d;

    logic        vsync_edge, period_valid, lose_lock;
    logic [2:0]  period_class;
    logic [3:0]  agree_next;

    // cnt_q in the edge cycle is the period just completed
    assign vsync_edge   = hist_q & ~sync2_q;
    assign period_valid = (cnt_q >= MIN_CYC) && (cnt_q <= MAX_CYC);
    assign period_class = (cnt_q > THR_CYC) ? FMT_PAL : FMT_NTSC;

    always_comb begin
        sync1_d    = vsync_in;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        state_d    = state_q;
        agree_d    = agree_q;
        miss_d     = miss_q;
        cand_d     = cand_q;
        format_d   = format_q;
        locked_d   = locked_q;
        period_d   = period_q;
        lost_d     = 1'b0;
        lose_lock  = 1'b0;
        agree_next = '0;

        if (vsync_edge)
            cnt_d = 32'd1;
        else if (cnt_q < TIMEOUT_CYC)
            cnt_d = cnt_q + 32'd1;
        else
            cnt_d = cnt_q;

        if (!enable_in) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            agree_d  = '0;
            miss_d   = '0;
            cand_d   = FMT_NONE;
            format_d = FMT_NONE;
            locked_d = 1'b0;
            period_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end
                S_ARM: begin
                    if (vsync_edge) begin
                        state_d = S_ACQUIRE;
                        agree_d = '0;
                    end
                end
                S_ACQUIRE: begin
                    if (vsync_edge) begin
                        if (!period_valid) begin
                            agree_d = '0;
                        end else begin
                            period_d   = cnt_q;
                            agree_next = (period_class == cand_q) ? agree_q + 4'd1 : 4'd1;
                            cand_d     = period_class;
                            agree_d    = agree_next;
                            if (agree_next == CONFIRM) begin
                                state_d  = S_LOCKED;
                                format_d = period_class;
                                locked_d = 1'b1;
                                miss_d   = '0;
                                agree_d  = '0;
                            end
                        end
                    end else if (cnt_q == TIMEOUT_CYC) begin
                        state_d = S_ARM;
                        agree_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (vsync_edge) begin
                        if (period_valid && (period_class == format_q)) begin
                            miss_d   = '0;
                            period_d = cnt_q;
                        end else if (miss_q + 4'd1 == CONFIRM) begin
                            lose_lock = 1'b1;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end else if (cnt_q == TIMEOUT_CYC) begin
                        lose_lock = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (lose_lock) begin
                state_d  = S_ACQUIRE;
                agree_d  = '0;
                miss_d   = '0;
                format_d = FMT_NONE;
                locked_d = 1'b0;
                lost_d   = 1'b1;
            end
        end
    end

`ifdef SAVOMAX_CSYNC_GATE_EN
    logic csync_q, csync_d;
    // Gate follows the next lock state so it switches with locked_out
    assign csync_d   = locked_d ? csync_in : 1'b1;
    assign csync_out = csync_q;
`else
    assign csync_out = csync_in;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            hist_q   <= 1'b1;
            cnt_q    <= '0;
            agree_q  <= '0;
            miss_q   <= '0;
            cand_q   <= FMT_NONE;
            format_q <= FMT_NONE;
            locked_q <= 1'b0;
            period_q <= '0;
            lost_q   <= 1'b0;
`ifdef SAVOMAX_CSYNC_GATE_EN
            csync_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            hist_q   <= hist_d;
            cnt_q    <= cnt_d;
            agree_q  <= agree_d;
            miss_q   <= miss_d;
            cand_q   <= cand_d;
            format_q <= format_d;
            locked_q <= locked_d;
            period_q <= period_d;
            lost_q   <= lost_d;
`ifdef SAVOMAX_CSYNC_GATE_EN
            csync_q  <= csync_d;
`endif
        end
    end

    assign format_out = format_q;
    assign locked_out = locked_q;
    assign period_out = period_q;
    assign lost_out   = lost_q;

endmodule

// File: tb/tb_vmode_lock_ctrl.sv
// Bench for vmode_lock_ctrl at CLK_FREQ=25_000 (cycle constants one tenth of the defaults).
// Expected behaviour comes from a per-edge classification model with a history queue.
module tb_vmode_lock_ctrl;
    localparam int CONFIRM = 4;
    localparam int THR     = 25 * 18;
    localparam int MIN_P   = 25 * 12;
    localparam int MAX_P   = 25 * 25;
    localparam int TMO     = 25 * 50;
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_NTSC = 3'b010;
    localparam logic [2:0] F_PAL  = 3'b100;

    logic        clk_in = 1'b0;
    logic        rst_in, enable_in, vsync_in, csync_in;
    logic        csync_out, locked_out, lost_out;
    logic [2:0]  format_out;
    logic [31:0] period_out;

    always #5 clk_in = ~clk_in;

    vmode_lock_ctrl #(
        .CLK_FREQ(25_000),
        .PAL_THRESHOLD_MS(18),
        .MIN_PERIOD_MS(12),
        .MAX_PERIOD_MS(25),
        .TIMEOUT_MS(50),
        .CONFIRM_COUNT(CONFIRM)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .enable_in(enable_in),
        .vsync_in(vsync_in),
        .csync_in(csync_in),
        .csync_out(csync_out),
        .format_out(format_out),
        .locked_out(locked_out),
        .period_out(period_out),
        .lost_out(lost_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int lost_seen = 0;
    int lost_wide = 0;
    logic lost_prev = 1'b0;

    // Reference model state
    bit          m_armed;
    bit          m_locked;
    logic [2:0]  m_fmt;
    logic [31:0] m_period;
    int          m_miss;
    int          m_lost = 0;
    logic [2:0]  acq_q[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Count lost pulses and flag any that last more than one cycle
    always @(negedge clk_in) begin
        if (lost_out === 1'b1) begin
            lost_seen++;
            if (lost_prev) lost_wide++;
        end
        lost_prev = (lost_out === 1'b1);
    end

    function automatic logic [2:0] classify(input int p);
        if (p < MIN_P || p > MAX_P) return F_NONE;
        return (p > THR) ? F_PAL : F_NTSC;
    endfunction

    function automatic int trailingRun();
        int n = 0;
        if (acq_q.size() == 0) return 0;
        if (acq_q[$] == F_NONE) return 0;
        for (int i = acq_q.size() - 1; i >= 0; i--) begin
            if (acq_q[i] == acq_q[$]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic modelReset();
        m_armed  = 0;
        m_locked = 0;
        m_fmt    = F_NONE;
        m_period = '0;
        m_miss   = 0;
        acq_q.delete();
    endtask

    task automatic modelTimeout();
        if (m_locked) begin
            m_lost++;
            m_locked = 0;
            m_fmt    = F_NONE;
        end
        m_armed = 0;
        m_miss  = 0;
        acq_q.delete();
    endtask

    task automatic modelEdge(input int gap);
        logic [2:0] c;
        if (m_armed && gap > TMO) modelTimeout();
        if (!m_armed) begin
            m_armed = 1;
            acq_q.delete();
            return;
        end
        c = classify(gap);
        if (m_locked) begin
            if (c == m_fmt) begin
                m_miss   = 0;
                m_period = gap;
            end else begin
                m_miss++;
                if (m_miss == CONFIRM) begin
                    m_lost++;
                    m_locked = 0;
                    m_fmt    = F_NONE;
                    m_miss   = 0;
                    acq_q.delete();
                end
            end
        end else begin
            if (c != F_NONE) m_period = gap;
            acq_q.push_back(c);
            if (trailingRun() >= CONFIRM) begin
                m_locked = 1;
                m_fmt    = c;
                m_miss   = 0;
            end
        end
    endtask

    function automatic logic expCsync(input logic cs);
`ifdef SAVOMAX_CSYNC_GATE_EN
        return m_locked ? cs : 1'b1;
`else
        return cs;
`endif
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "/locked"}, 32'(locked_out), 32'(m_locked));
        checkVal({tag, "/format"}, 32'(format_out), 32'(m_locked ? m_fmt : F_NONE));
        checkVal({tag, "/period"}, period_out, m_period);
        checkVal({tag, "/lost_now"}, 32'(lost_out), 32'd0);
        checkVal({tag, "/lost_count"}, 32'(lost_seen), 32'(m_lost));
    endtask

    // One vsync period of p cycles, beginning with a falling edge
    task automatic applyStimulus(input int p, input string tag);
        logic cs;
        @(posedge clk_in); #1;
        vsync_in = 1'b0;
        modelEdge(cyc - last_fall);
        last_fall = cyc;
        cs = 1'($urandom_range(0, 1));
        for (int k = 1; k < p; k++) begin
            @(posedge clk_in); #1;
            if (k == 4) begin
                checkOutput(tag);
                csync_in = cs;
            end
            if (k == 5) checkVal({tag, "/csync"}, 32'(csync_out), 32'(expCsync(cs)));
            if (k == p / 2) vsync_in = 1'b1;
        end
        if (p > TMO + 5) begin
            modelTimeout();
            checkOutput({tag, "/timeout"});
        end
    endtask

    task automatic restart(input string tag);
        @(posedge clk_in); #1;
        enable_in = 1'b0;
        @(posedge clk_in); #1;
        modelReset();
        checkOutput({tag, "/off"});
        enable_in = 1'b1;
    endtask

    int bvals[6]  = '{450, 451, 299, 626, 300, 625};
    int block[6]  = '{1, 1, 0, 0, 1, 1};
    int bfmt[6]   = '{2, 4, 0, 0, 2, 4};

    initial begin
        int cat, run, p, n;
        rst_in    = 1'b1;
        enable_in = 1'b0;
        vsync_in  = 1'b1;
        csync_in  = 1'b1;
        modelReset();
        #12;
        checkOutput("reset");
        @(posedge clk_in); #3;
        rst_in    = 1'b0;
        enable_in = 1'b1;

        // PAL lock
        repeat (5) applyStimulus(500, "pal");
        checkVal("pal_locked", 32'(locked_out), 32'd1);
        checkVal("pal_format", 32'(format_out), 32'(F_PAL));
        checkVal("pal_period", period_out, 32'd500);
        applyStimulus(500, "pal");

        // NTSC lock
        restart("ntsc");
        repeat (5) applyStimulus(417, "ntsc");
        checkVal("ntsc_locked", 32'(locked_out), 32'd1);
        checkVal("ntsc_format", 32'(format_out), 32'(F_NTSC));
        applyStimulus(417, "ntsc");

        // Loss by timeout, then relock
        restart("loss");
        repeat (4) applyStimulus(500, "loss_lock");
        applyStimulus(1300, "loss_hold");
        checkVal("loss_format", 32'(format_out), 32'(F_NONE));
        checkVal("loss_pulses", 32'(lost_seen), 32'd1);
        repeat (5) applyStimulus(500, "loss_relock");
        checkVal("relock_locked", 32'(locked_out), 32'd1);

        // Single glitch tolerated, sustained format change re-acquires
        restart("glitch");
        repeat (5) applyStimulus(500, "glitch_lock");
        applyStimulus(200, "glitch_short");
        repeat (3) applyStimulus(500, "glitch_after");
        checkVal("glitch_held", 32'(locked_out), 32'd1);
        repeat (9) applyStimulus(417, "switch");
        checkVal("switch_format", 32'(format_out), 32'(F_NTSC));

        // Classification boundaries
        for (int i = 0; i < 6; i++) begin
            restart("bound");
            repeat (6) applyStimulus(bvals[i], "bound");
            checkVal($sformatf("bound_%0d_locked", bvals[i]), 32'(locked_out), 32'(block[i]));
            checkVal($sformatf("bound_%0d_format", bvals[i]), 32'(format_out), 32'(bfmt[i]));
        end

        // Disable while locked, then reset during acquisition
        restart("ctl");
        repeat (2) applyStimulus(500, "ctl_acq");
        #2;
        rst_in = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_mid");
        @(posedge clk_in);
        @(posedge clk_in); #3;
        rst_in = 1'b0;

        // Randomized runs of mixed classes
        n = 0;
        while (n < 48) begin
            cat = $urandom_range(0, 9);
            run = $urandom_range(1, 5);
            for (int r = 0; r < run; r++) begin
                if (cat == 0)      p = $urandom_range(200, MIN_P - 1);
                else if (cat == 1) p = $urandom_range(MAX_P + 1, 700);
                else if (cat < 6)  p = $urandom_range(MIN_P, THR);
                else               p = $urandom_range(THR + 1, MAX_P);
                applyStimulus(p, "rnd");
                n++;
            end
        end

        checkVal("lost_width", 32'(lost_wide), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
